// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU command encoding, RV32I opcode/funct constants
// and the control bundle produced by instr_decoder.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0101
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    alu_op_t alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    use_rs2;
    logic    use_imm;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I-subset decoder: instruction word to control bundle,
// immediate and register fields. Unsupported encodings decode as a flag-free ADD.
module instr_decoder
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal,
  output logic            o_use_rs1,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_i_imm;
  logic [XLEN-1:0] w_s_imm;
  logic            w_bad;
  ctrl_t           w_ctrl;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign o_rd     = i_instr[11:7];
  assign w_i_imm  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_s_imm  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_ADD;
    w_bad         = 1'b0;
    o_imm         = w_i_imm;
    case (w_opcode)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.use_rs2   = 1'b1;
        if (w_f3 == F3_ADD_SUB && w_f7 == F7_SUB) w_ctrl.alu_op = ALU_SUB;
        else if (w_f7 != F7_BASE) w_bad = 1'b1;
        else begin
          case (w_f3)
            F3_ADD_SUB: w_ctrl.alu_op = ALU_ADD;
            F3_AND:     w_ctrl.alu_op = ALU_AND;
            F3_OR:      w_ctrl.alu_op = ALU_OR;
            F3_SLT:     w_ctrl.alu_op = ALU_SLT;
            default:    w_bad = 1'b1;
          endcase
        end
      end
      OP_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.use_imm   = 1'b1;
        case (w_f3)
          F3_ADD_SUB: w_ctrl.alu_op = ALU_ADD;
          F3_AND:     w_ctrl.alu_op = ALU_AND;
          F3_OR:      w_ctrl.alu_op = ALU_OR;
          F3_SLT:     w_ctrl.alu_op = ALU_SLT;
          default:    w_bad = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.use_imm   = 1'b1;
        w_bad            = (w_f3 != F3_WORD);
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.use_rs2   = 1'b1;
        w_ctrl.use_imm   = 1'b1;
        o_imm            = w_s_imm;
        w_bad            = (w_f3 != F3_WORD);
      end
      OP_BRANCH: begin
        w_ctrl.alu_op  = ALU_SUB;
        w_ctrl.branch  = 1'b1;
        w_ctrl.use_rs2 = 1'b1;
        w_bad          = (w_f3 != F3_BEQ);
      end
      default: w_bad = 1'b1;
    endcase
    // Unsupported words become a source-free, side-effect-free ADD.
    if (w_bad) begin
      w_ctrl        = '0;
      w_ctrl.alu_op = ALU_ADD;
    end
    if (o_rd == 5'd0) w_ctrl.reg_write = 1'b0;
  end

  assign o_ctrl    = w_ctrl;
  assign o_illegal = w_bad;
  assign o_use_rs1 = !w_bad;

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes via instr_decoder, selects ALU operands and holds the ID/EX
// register with valid/ready handshakes, load-use bubble and flush.
// Optional illegal-instruction flag output: define DECODE_ILLEGAL_TRAP_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              flush,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_rdata,
  input  logic [XLEN-1:0]   rs2_rdata,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_alu_control,
  output logic [XLEN-1:0]   ex_srca,
  output logic [XLEN-1:0]   ex_srcb,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic              ex_illegal,
`endif
  output logic              ex_branch
);

  // Handshake: a transfer happens on a side whenever its valid and ready are
  // both high at the rising edge; ex_* stay frozen while ex_valid && !ex_ready.
  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  logic              w_illegal;
  logic              w_use_rs1;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic              w_stall;
  logic              w_accept;

  logic              r_valid;
  logic [3:0]        r_alu;
  logic [XLEN-1:0]   r_srca;
  logic [XLEN-1:0]   r_srcb;
  logic [XLEN-1:0]   r_store;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;

  instr_decoder #(.XLEN(XLEN)) u_dec (
    .i_instr   (id_instr),
    .o_ctrl    (w_ctrl),
    .o_imm     (w_imm),
    .o_illegal (w_illegal),
    .o_use_rs1 (w_use_rs1),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd)
  );

  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  // Load-use hazard: the load in EX has not produced its data yet.
  assign w_stall = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                   ((w_use_rs1 && (w_rs1 == r_rd)) ||
                    (w_ctrl.use_rs2 && (w_rs2 == r_rd)));

  assign id_ready = (!r_valid || ex_ready) && !w_stall && !flush;
  assign w_accept = id_valid && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_alu       <= 4'b0000;
      r_srca      <= '0;
      r_srcb      <= '0;
      r_store     <= '0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_alu       <= w_ctrl.alu_op;
      r_srca      <= rs1_rdata;
      r_srcb      <= w_ctrl.use_imm ? w_imm : rs2_rdata;
      r_store     <= rs2_rdata;
      r_pc        <= id_pc;
      r_rd        <= w_rd;
      r_reg_write <= w_ctrl.reg_write;
      r_mem_read  <= w_ctrl.mem_read;
      r_mem_write <= w_ctrl.mem_write;
      r_branch    <= w_ctrl.branch;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_illegal <= 1'b0;
    else if (!flush && w_accept) r_illegal <= w_illegal;
  end
  assign ex_illegal = r_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal;
`endif

  assign ex_valid       = r_valid;
  assign ex_alu_control = r_alu;
  assign ex_srca        = r_srca;
  assign ex_srcb        = r_srcb;
  assign ex_store_data  = r_store;
  assign ex_pc          = r_pc;
  assign ex_rd          = r_rd;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_branch      = r_branch;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the pipelined core. Decodes a 32-bit RV32I subset into the 4-bit ALU command encoding, selects the ALU operands, and registers the result into the ID/EX pipeline register.
- Produces everything the EX-stage ALU consumes: the command, srca and srcb.
- Uses valid/ready handshakes upstream (IF/ID) and downstream (EX).
- Inserts a load-use bubble and honours a pipeline flush.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_ready  out  1  stage accepts id_instr this cycle
- id_instr  in  32  instruction word
- id_pc  in  XLEN  PC of id_instr
- flush  in  1  kill the in-flight ID/EX entry (branch taken)
- rs1_addr  out  REG_AW  combinational, id_instr[19:15]
- rs2_addr  out  REG_AW  combinational, id_instr[24:20]
- rs1_rdata  in  XLEN  register-file read data, same cycle
- rs2_rdata  in  XLEN  register-file read data, same cycle
- ex_valid  out  1  ID/EX entry valid
- ex_ready  in  1  EX consumes the entry this cycle
- ex_alu_control  out  4  ALU command
- ex_srca  out  XLEN  ALU operand A
- ex_srcb  out  XLEN  ALU operand B
- ex_store_data  out  XLEN  rs2 value for stores/branches
- ex_pc  out  XLEN  PC passthrough
- ex_rd  out  REG_AW  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  control flags

Behaviour:
- Reset (async, immediate): ex_valid=0. All ex_* data and flags are 0, and ex_alu_control=4'b0000.
- ALU encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101.
  - No other code is ever emitted while ex_valid=1.
- Decode:
  - R-type (0110011): add/sub (funct7[5] selects SUB), and, or, slt. srcb=rs2.
  - I-ALU (0010011): addi, andi, ori, slti. srcb=sign-extended imm[31:20].
  - LW (0000011, f3=010): ADD, I-imm, mem_read, reg_write.
  - SW (0100011, f3=010): ADD, S-imm {instr[31:25],instr[11:7]} sign-extended, mem_write, store_data=rs2.
  - BEQ (1100011, f3=000): SUB, srcb=rs2, branch=1, reg_write=0.
  - srca=rs1_rdata in all cases.
  - reg_write is forced 0 when rd=0.
- Handshake:
  - id_ready = (!ex_valid || ex_ready) && !stall && !flush.
  - Load: on id_valid && id_ready, capture the decoded fields; ex_valid=1 next cycle.
  - Bubble: if ex_ready && !(id_valid && id_ready), ex_valid=0 next cycle.
  - Hold: if ex_valid && !ex_ready, all ex_* hold stable.
- Load-use stall:
  - stall = ex_valid && ex_mem_read && ex_rd!=0 && id_valid && ex_rd matches a used source.
  - rs1 is used by all supported ops; rs2 is used by R-type, SW and BEQ.
  - During a stall the instruction is not accepted. If ex_ready, a bubble is written (ex_valid=0).
  - After the bubble the instruction is accepted on the following cycle: exactly 1 lost cycle.
- Flush:
  - flush=1: ex_valid=0 next cycle regardless of ex_ready; id_ready=0 this cycle.
  - Flush has priority over load and stall.
- Reset mid-operation discards the entry; there is no recovery state.
- Latency: 1 cycle from accept to ex_valid.
- Throughput: 1 instruction per cycle when there is no stall.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN
- Defined:
  - Adds output ex_illegal (1 bit, reset 0).
  - An unsupported opcode/funct is accepted with ex_valid=1, ex_illegal=1, all write/mem/branch flags 0, ex_alu_control=ADD.
  - ex_illegal clears on the next loaded entry.
- Undefined: an unsupported instruction is accepted and decoded as a NOP (ADD, all flags 0). The port is absent.

Decomposition:
- Package decode_pkg:
  - alu_op_t enum (ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_SLT=4'b0101), shared with the ALU.
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH).
  - Funct3/funct7 constants.
  - ctrl_t packed struct (alu_op, reg_write, mem_read, mem_write, branch, use_rs2, use_imm).
- Sub-module: instr_decoder, purely combinational: instruction -> ctrl_t plus immediate. Handshake, stall, flush and the pipeline register stay in decode_stage.

Test Plan:
- Reset asserted mid-stream with ex_valid=1 -> ex_valid=0 and ex_alu_control=0 immediately, with no clock edge needed.
- id_instr=0x402081B3 (sub x3,x1,x2), rs1_rdata=10, rs2_rdata=3, ex_ready=1 -> next cycle: ex_valid=1, alu=0001, srca=10, srcb=3, rd=3, reg_write=1.
- id_instr=0x0020A223 (sw x2,4(x1)), rs1=0x100, rs2=0xAB -> alu=0000, srcb=4, store_data=0xAB, mem_write=1, reg_write=0.
- Load-use:
  - Stimulus: 0x0080A283 (lw x5,8(x1)) followed by 0x00528333 (add x6,x5,x5), ex_ready=1.
  - Response: cycle 1 lw in EX; cycle 1 id_ready=0 and a bubble is written; add accepted the next cycle, so add reaches EX 2 cycles after lw.
- ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable and id_ready=0. flush=1 during the stall -> ex_valid=0 next cycle.
- id_instr=0xFFFFFFFF:
  - With DECODE_ILLEGAL_TRAP_EN defined: ex_illegal=1, all flags 0.
  - Without it: NOP with ex_valid=1 and all flags 0.
